// File: rtl/psum_drain_if.sv
// psum_drain_if: row-in / element-out handshake bundle for psum_drain.
//   row_valid, row_ready, psums_in  : one full psum row from the array
//   psum_valid, psum_ready          : element stream handshake
//   psum_data, psum_col, psum_last  : current element, its column, last-column flag
// Modports: master = upstream/downstream environment, slave = psum_drain.
interface psum_drain_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int PSUM_WIDTH = 32
);
  localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;

  logic                             row_valid;
  logic                             row_ready;
  logic [ARRAY_SIZE*PSUM_WIDTH-1:0] psums_in;
  logic                             psum_valid;
  logic                             psum_ready;
  logic [PSUM_WIDTH-1:0]            psum_data;
  logic [COL_W-1:0]                 psum_col;
  logic                             psum_last;

  modport master (
    output row_valid, psums_in, psum_ready,
    input  row_ready, psum_valid, psum_data, psum_col, psum_last
  );

  modport slave (
    input  row_valid, psums_in, psum_ready,
    output row_ready, psum_valid, psum_data, psum_col, psum_last
  );
endinterface

// File: rtl/psum_drain.sv
// psum_drain: buffers whole psum rows in a DEPTH-entry FIFO and serializes
// each row into a stream of single elements, column 0 first.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   flush       : synchronous discard of buffered rows and the row in flight
//   bus (slave) : row input handshake and element output handshake
//   rows_done   : wrapping count of rows whose last element was accepted
module psum_drain #(
  parameter int ARRAY_SIZE = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  psum_drain_if.slave  bus,
  output logic [15:0]  rows_done
);
  localparam int COL_W = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
  localparam int ROW_W = ARRAY_SIZE * PSUM_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state_r, state_s;
  logic [ROW_W-1:0]      fifo_mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_s;
  logic [ROW_W-1:0]      cur_row_r;
  logic [ROW_W-1:0]      head_row_s;
  logic [COL_W-1:0]      col_r, col_s;
  logic [PSUM_WIDTH-1:0] data_r, data_s;
  logic                  last_r;
  logic                  row_ready_r;
  logic [15:0]           rows_done_r;
  logic                  push_s, pop_s, done_s, fifo_empty_s;

  // Select one column of a packed row.
  function automatic logic [PSUM_WIDTH-1:0] pick_elem(input logic [ROW_W-1:0] row,
                                                      input logic [COL_W-1:0] idx);
    logic [PSUM_WIDTH-1:0] r;
    r = {PSUM_WIDTH{1'b0}};
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      if (idx == COL_W'(c)) begin
        r = row[c*PSUM_WIDTH +: PSUM_WIDTH];
      end
    end
    return r;
  endfunction

  // A push is only honoured when the registered ready was high and no flush.
  assign push_s       = bus.row_valid && row_ready_r && !flush;
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign head_row_s   = fifo_mem_r[rd_ptr_r];

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state, FIFO pop, column advance and next element value.
  always_comb begin
    state_s = state_r;
    pop_s   = 1'b0;
    done_s  = 1'b0;
    col_s   = col_r;
    data_s  = data_r;
    if (flush) begin
      state_s = IDLE;
      col_s   = {COL_W{1'b0}};
      data_s  = {PSUM_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_s = SEND;
            col_s   = {COL_W{1'b0}};
            data_s  = pick_elem(head_row_s, {COL_W{1'b0}});
          end else begin
            state_s = IDLE;
          end
        end
        SEND: begin
          if (bus.psum_ready) begin
            if (col_r == LAST_COL) begin
              done_s = 1'b1;
              col_s  = {COL_W{1'b0}};
              // Chain straight into the next buffered row without a bubble.
              if (!fifo_empty_s) begin
                pop_s   = 1'b1;
                state_s = SEND;
                data_s  = pick_elem(head_row_s, {COL_W{1'b0}});
              end else begin
                state_s = IDLE;
              end
            end else begin
              col_s  = col_r + COL_W'(1);
              data_s = pick_elem(cur_row_r, col_r + COL_W'(1));
            end
          end else begin
            state_s = SEND;
          end
        end
        default: begin
          state_s = IDLE;
          col_s   = {COL_W{1'b0}};
        end
      endcase
    end
  end

  // FIFO occupancy after this edge; a simultaneous push and pop cancel.
  always_comb begin
    count_s = count_r;
    if (flush) begin
      count_s = {CNT_W{1'b0}};
    end else begin
      count_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Row storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.psums_in;
    end
  end

  // Pointers, occupancy, current row, output registers and row counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      cur_row_r   <= {ROW_W{1'b0}};
      col_r       <= {COL_W{1'b0}};
      data_r      <= {PSUM_WIDTH{1'b0}};
      last_r      <= 1'b0;
      row_ready_r <= 1'b1;
      rows_done_r <= 16'h0000;
    end else begin
      count_r <= count_s;
      col_r   <= col_s;
      data_r  <= data_s;
      last_r  <= (col_s == LAST_COL);
      // Ready reflects next-cycle occupancy, so a pop while full is only
      // visible upstream one cycle later.
      row_ready_r <= (count_s != FULL_CNT);
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
          cur_row_r <= head_row_s;
        end
        if (done_s) begin
          rows_done_r <= rows_done_r + 16'd1;
        end
      end
    end
  end

  assign bus.row_ready  = row_ready_r;
  assign bus.psum_valid = (state_r == SEND);
  assign bus.psum_data  = data_r;
  assign bus.psum_col   = col_r;
  assign bus.psum_last  = last_r;
  assign rows_done      = rows_done_r;

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed stimulus with a scoreboard queue; a negedge monitor
// pops expected elements on every output handshake and checks hold stability.
module tb_psum_drain;
  localparam int AS = 8;
  localparam int PW = 32;

  typedef struct packed {
    logic [PW-1:0] data;
    logic [2:0]    col;
    logic          last;
  } elem_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [15:0] rows_done;

  elem_t exp_q[$];
  int    chk_cnt  = 0;
  int    pass_cnt = 0;

  psum_drain_if #(.ARRAY_SIZE(AS), .PSUM_WIDTH(PW)) bus ();

  psum_drain #(.ARRAY_SIZE(AS), .PSUM_WIDTH(PW), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .rows_done (rows_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [AS*PW-1:0] make_row(input logic [PW-1:0] base);
    logic [AS*PW-1:0] r;
    for (int c = 0; c < AS; c++) r[c*PW +: PW] = base + PW'(c);
    return r;
  endfunction

  // Present a row, wait (bounded) for ready, record its elements, complete on an edge.
  task automatic push_row(input logic [PW-1:0] base);
    int waited = 0;
    bus.row_valid = 1'b1;
    bus.psums_in  = make_row(base);
    while (!bus.row_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 300) begin
      check("push_timeout", 64'd1, 64'd0);
    end else begin
      for (int c = 0; c < AS; c++) begin
        elem_t e;
        e.data = base + PW'(c);
        e.col  = 3'(c);
        e.last = (c == AS - 1);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    bus.row_valid = 1'b0;
  endtask

  task automatic wait_rows(input logic [15:0] target);
    int n = 0;
    while (rows_done !== target && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rows_done", rows_done, target);
  endtask

  // Monitor: compare each handshaken element and check stability while stalled.
  logic          held_v = 1'b0;
  logic [PW-1:0] held_data;
  logic [2:0]    held_col;
  always @(negedge clk) begin
    if (rst_n) begin
      if (held_v && bus.psum_valid) begin
        check("hold_data", bus.psum_data, held_data);
        check("hold_col", bus.psum_col, held_col);
      end
      if (bus.psum_valid && bus.psum_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_elem", 64'd1, 64'd0);
        end else begin
          elem_t e;
          e = exp_q.pop_front();
          check("elem_data", bus.psum_data, e.data);
          check("elem_col", bus.psum_col, e.col);
          check("elem_last", bus.psum_last, e.last);
        end
      end
      held_v    = bus.psum_valid && !bus.psum_ready;
      held_data = bus.psum_data;
      held_col  = bus.psum_col;
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int run;
    int w;
    bus.row_valid  = 1'b0;
    bus.psums_in   = '0;
    bus.psum_ready = 1'b1;
    flush = 1'b0;
    rst_n = 1'b0;
    #12;
    // Reset state
    check("rst_valid", bus.psum_valid, 1'b0);
    check("rst_ready", bus.row_ready, 1'b1);
    check("rst_rows", rows_done, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single row, values 1..8, latency of two edges to first valid
    push_row(32'd1);
    check("lat_idle", bus.psum_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_valid", bus.psum_valid, 1'b1);
    check("lat_col", bus.psum_col, 3'd0);
    check("lat_data", bus.psum_data, 32'd1);
    wait_rows(16'd1);
    check("single_idle", bus.psum_valid, 1'b0);

    // Back-to-back: 3 rows, 24 elements with no valid gap
    @(posedge clk);
    #1;
    fork
      begin
        push_row(32'h100);
        push_row(32'h200);
        push_row(32'h300);
      end
      begin
        run = 0;
        w   = 0;
        @(negedge clk);
        while (!bus.psum_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        while (bus.psum_valid && run < 100) begin
          run++;
          @(negedge clk);
        end
        check("b2b_run", run, 24);
      end
    join
    wait_rows(16'd4);

    // Full: 1 row in the current register plus 4 in the FIFO
    bus.psum_ready = 1'b0;
    @(posedge clk);
    #1;
    push_row(32'h1000);
    push_row(32'h2000);
    push_row(32'h3000);
    push_row(32'h4000);
    push_row(32'h5000);
    check("full_ready", bus.row_ready, 1'b0);
    fork
      push_row(32'h6000);
      begin
        repeat (3) begin
          @(negedge clk);
          check("full_hold_ready", bus.row_ready, 1'b0);
          check("full_hold_data", bus.psum_data, 32'h1000);
        end
        @(posedge clk);
        #1;
        bus.psum_ready = 1'b1;
      end
    join
    wait_rows(16'd10);

    // Backpressure: toggle ready every cycle
    fork
      begin
        push_row(32'h7000);
        push_row(32'h8000);
      end
      for (int i = 0; i < 200 && rows_done != 16'd12; i++) begin
        @(posedge clk);
        #1;
        bus.psum_ready = !bus.psum_ready;
      end
    join
    wait_rows(16'd12);
    bus.psum_ready = 1'b0;
    @(posedge clk);
    #1;

    // Flush mid-row at column 3 with two rows buffered
    push_row(32'h9000);
    push_row(32'hA000);
    push_row(32'hB000);
    bus.psum_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.psum_ready = 1'b0;
    check("pre_flush_col", bus.psum_col, 3'd3);
    check("pre_flush_data", bus.psum_data, 32'h9003);
    flush         = 1'b1;
    bus.row_valid = 1'b1;
    bus.psums_in  = make_row(32'hC000);
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.row_valid = 1'b0;
    exp_q.delete();
    check("flush_valid", bus.psum_valid, 1'b0);
    check("flush_col", bus.psum_col, 3'd0);
    check("flush_ready", bus.row_ready, 1'b1);
    check("flush_rows", rows_done, 16'd12);
    bus.psum_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_empty", bus.psum_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    push_row(32'hD000);
    wait_rows(16'd13);

    // Async reset between edges during SEND
    @(posedge clk);
    #1;
    push_row(32'hE000);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", bus.psum_valid, 1'b0);
    check("arst_col", bus.psum_col, 3'd0);
    check("arst_last", bus.psum_last, 1'b0);
    check("arst_data", bus.psum_data, 32'd0);
    check("arst_rows", rows_done, 16'd0);
    check("arst_ready", bus.row_ready, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    push_row(32'hF000);
    @(posedge clk);
    #1;
    check("post_rst_valid", bus.psum_valid, 1'b1);
    check("post_rst_data", bus.psum_data, 32'hF000);
    wait_rows(16'd1);

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 8, number of psum columns per row.
REQ-002 SHALL have parameter PSUM_WIDTH, default 32, bits per psum.
REQ-003 SHALL have parameter DEPTH, default 4, row-buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight data.
REQ-007 SHALL have port row_valid  input  1  a psum row is presented.
REQ-008 SHALL have port row_ready  output  1  block can accept a row.
REQ-009 SHALL have port psums_in  input  ARRAY_SIZE*PSUM_WIDTH  row; column c at bits [c*PSUM_WIDTH +: PSUM_WIDTH].
REQ-010 SHALL have port psum_valid  output  1  psum_data holds a valid element.
REQ-011 SHALL have port psum_ready  input  1  downstream accepts element.
REQ-012 SHALL have port psum_data  output  PSUM_WIDTH  current element.
REQ-013 SHALL have port psum_col  output  clog2(ARRAY_SIZE)  column index of psum_data.
REQ-014 SHALL have port psum_last  output  1  high while psum_col == ARRAY_SIZE-1.
REQ-015 SHALL have port rows_done  output  16  count of fully drained rows.

Function
REQ-016 SHALL accept a row on a rising edge where row_valid && row_ready, writing psums_in to the FIFO tail.
REQ-017 SHALL drive row_ready = !fifo_full, a registered-state function with no combinational path from any input.
REQ-018 SHALL implement the FIFO as DEPTH entries with wrapping read/write pointers and a count 0..DEPTH.
REQ-019 SHALL hold the row being serialized in a separate current-row register, outside the FIFO count.
REQ-020 SHALL implement FSM states IDLE and SEND.
REQ-021 SHALL, in IDLE with FIFO non-empty, pop the head into the current row, set psum_col=0, and enter SEND on the same edge.
REQ-022 SHALL drive psum_valid high exactly in SEND, with psum_data = current_row[psum_col].
REQ-023 SHALL make a row accepted into an empty FIFO in IDLE at edge N present column 0 with psum_valid high after edge N+1.
REQ-024 SHALL increment psum_col on each SEND handshake (psum_valid && psum_ready) below ARRAY_SIZE-1.
REQ-025 SHALL, on a handshake with psum_last high, increment rows_done; then, if the FIFO is non-empty, pop the next row with psum_col=0 and stay in SEND (no bubble), else go to IDLE.
REQ-026 SHALL hold psum_data, psum_col and psum_valid stable while psum_valid && !psum_ready.
REQ-027 SHALL let a push and a pop on the same edge leave the count unchanged; with the FIFO full, row_ready stays low that cycle even if a pop occurs.
REQ-028 SHALL let rows_done wrap from 16'hFFFF to 0.
REQ-029 SHALL, on flush, empty the FIFO, zero the pointers, go to IDLE, set psum_col=0, and ignore any simultaneous row push; rows_done is kept.
REQ-030 SHALL not count a row partially drained at flush in rows_done.

Reset
REQ-031 SHALL, on rst_n low, immediately and regardless of clk, set: FIFO empty, pointers 0, state IDLE, psum_valid 0, psum_col 0, psum_last 0, psum_data 0, rows_done 0, row_ready 1.
REQ-032 SHALL discard any row and partial serialization in progress when reset is asserted mid-operation.
REQ-033 SHALL permit row acceptance on the first rising edge after rst_n deasserts.

Verification
REQ-034 SHALL cover single row: psums_in = column c value c+1, psum_ready=1 -> 8 consecutive elements 1..8, cols 0..7, psum_last on col 7, rows_done=1, then IDLE.
REQ-035 SHALL cover back-to-back: 3 rows pushed on consecutive cycles, psum_ready=1 -> 24 elements with no valid gap, rows_done=3.
REQ-036 SHALL cover full: psum_ready=0, push 6 rows -> 1 row in current register plus 4 in FIFO, row_ready=0 after the 5th acceptance, 6th held until a row frees.
REQ-037 SHALL cover backpressure: toggle psum_ready every cycle -> each element held stable until handshake, order preserved.
REQ-038 SHALL cover flush mid-row at col 3 with 2 rows buffered -> psum_valid=0 next cycle, FIFO empty, rows_done unchanged.
REQ-039 SHALL cover async reset asserted between clock edges during SEND -> all outputs reach REQ-031 values before the next edge.
